// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment display source scheduler.
package seg7_pkg;

    localparam int SEG7_W       = 32;
    localparam int SEG7_IDX_W   = 3;
    localparam int SEG7_MAX_SRC = 8;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SHOW
    } seg7_state_e;

    function automatic logic [SEG7_MAX_SRC-1:0] onehot(input logic [SEG7_IDX_W-1:0] idx);
        onehot = SEG7_MAX_SRC'(1) << idx;
    endfunction

endpackage

// File: rtl/seg7_src_scheduler_if.sv
// Requester/display bus of the scheduler: master is the SoC side, slave is the scheduler.
interface seg7_src_scheduler_if #(
    parameter int NUM_SRC = 4
);
    import seg7_pkg::*;

    logic [NUM_SRC-1:0]        src_req;
    logic [SEG7_W*NUM_SRC-1:0] src_data;
    logic                      lock;
    logic [NUM_SRC-1:0]        src_grant;
    logic [SEG7_IDX_W-1:0]     cur_idx;
    logic                      disp_cs;
    logic [SEG7_W-1:0]         disp_data;

    modport master (
        output src_req, src_data, lock,
        input  src_grant, cur_idx, disp_cs, disp_data
    );

    modport slave (
        input  src_req, src_data, lock,
        output src_grant, cur_idx, disp_cs, disp_data
    );

endinterface

// File: rtl/seg7_rr_pick.sv
// Combinational round-robin picker: first set bit of mask after last_idx, last_idx itself scanned last.
module seg7_rr_pick
    import seg7_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]    mask,
    input  logic [SEG7_IDX_W-1:0] last_idx,
    output logic [SEG7_IDX_W-1:0] idx,
    output logic                  found
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [SEL_W-1:0] pos;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        // Scan from farthest to nearest so the nearest hit overwrites the others.
        for (int k = NUM_SRC; k >= 1; k--) begin
            pos = SEL_W'((int'(last_idx) + k) % NUM_SRC);
            if (mask[pos]) begin
                idx   = SEG7_IDX_W'(pos);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_src_scheduler.sv
// Round-robin time-sharing of the 7-segment display driver between NUM_SRC requesters.
// Optional SEG7_FORCE_EN adds force_en/force_idx to pin the display to one source.
module seg7_src_scheduler
    import seg7_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef SEG7_FORCE_EN
    input  logic                  force_en,
    input  logic [SEG7_IDX_W-1:0] force_idx,
`endif
    seg7_src_scheduler_if.slave   bus
);

    seg7_state_e           state_q,     state_d;
    logic [SEG7_IDX_W-1:0] cur_idx_q,   cur_idx_d;
    logic [CNT_W-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic [NUM_SRC-1:0]    grant_q,     grant_d;
    logic                  cs_q,        cs_d;
    logic [SEG7_W-1:0]     data_q,      data_d;

    logic [SEG7_W-1:0]     src_word [SEG7_MAX_SRC];
    logic [NUM_SRC-1:0]    pick_mask;
    logic [SEG7_IDX_W-1:0] pick_idx;
    logic                  pick_found;
    logic                  cur_present;
    logic                  expired;
    logic                  take_pick;

    // Out-of-range indices (e.g. a forced index >= NUM_SRC) read as zero.
    for (genvar g = 0; g < SEG7_MAX_SRC; g++) begin : g_word
        if (g < NUM_SRC) begin : g_src
            assign src_word[g] = bus.src_data[g*SEG7_W +: SEG7_W];
        end else begin : g_pad
            assign src_word[g] = '0;
        end
    end

    assign cur_present = |(bus.src_req & NUM_SRC'(onehot(cur_idx_q)));
    assign expired     = (dwell_cnt_q == CNT_W'(DWELL_CYCLES - 1));
    assign pick_mask   = (state_q == ST_IDLE) ? bus.src_req
                                              : (bus.src_req & ~NUM_SRC'(onehot(cur_idx_q)));

    seg7_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .mask     (pick_mask),
        .last_idx (cur_idx_q),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        grant_d     = grant_q;
        cs_d        = cs_q;
        data_d      = data_q;
        take_pick   = 1'b0;
`ifdef SEG7_FORCE_EN
        if (force_en) begin
            state_d     = ST_IDLE;
            cur_idx_d   = force_idx;
            dwell_cnt_d = '0;
            grant_d     = '0;
            cs_d        = 1'b1;
            data_d      = src_word[force_idx];
        end else
`endif
        begin
            case (state_q)
                ST_IDLE: begin
                    grant_d   = '0;
                    cs_d      = 1'b0;
                    take_pick = pick_found;
                end
                ST_SHOW: begin
                    cs_d        = 1'b1;
                    data_d      = src_word[cur_idx_q];
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                    if (!cur_present) begin
                        // A drop ends the dwell regardless of lock; with no one left, blank but keep data.
                        if (pick_found) begin
                            take_pick = 1'b1;
                        end else begin
                            state_d     = ST_IDLE;
                            grant_d     = '0;
                            cs_d        = 1'b0;
                            data_d      = data_q;
                            dwell_cnt_d = '0;
                        end
                    end else if (expired) begin
                        if (!bus.lock && pick_found) begin
                            take_pick = 1'b1;
                        end else begin
                            dwell_cnt_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (take_pick) begin
                state_d     = ST_SHOW;
                cur_idx_d   = pick_idx;
                dwell_cnt_d = '0;
                grant_d     = NUM_SRC'(onehot(pick_idx));
                cs_d        = 1'b1;
                data_d      = src_word[pick_idx];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cur_idx_q   <= SEG7_IDX_W'(NUM_SRC - 1);
            dwell_cnt_q <= '0;
            grant_q     <= '0;
            cs_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            dwell_cnt_q <= dwell_cnt_d;
            grant_q     <= grant_d;
            cs_q        <= cs_d;
            data_q      <= data_d;
        end
    end

    assign bus.src_grant = grant_q;
    assign bus.cur_idx   = cur_idx_q;
    assign bus.disp_cs   = cs_q;
    assign bus.disp_data = data_q;

endmodule

// File: tb/tb_seg7_src_scheduler.sv
// Self-checking bench for seg7_src_scheduler (NUM_SRC=4, DWELL_CYCLES=8); covers SEG7_FORCE_EN when defined.
module tb_seg7_src_scheduler;
    import seg7_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int DWELL   = 8;
    localparam int CNT_W   = 3;

    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;
    localparam logic [31:0] DC = 32'hCAFE_BABE;

    typedef struct {
        logic [3:0]  req;
        logic        lock;
        logic [31:0] d0;
        logic [3:0]  grant;
        logic        cs;
        logic [31:0] data;
        logic [2:0]  idx;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    seg7_src_scheduler_if #(.NUM_SRC(NUM_SRC)) bus ();

`ifdef SEG7_FORCE_EN
    logic       force_en = 1'b0;
    logic [2:0] force_idx = 3'd0;
`endif

    seg7_src_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DWELL_CYCLES (DWELL),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
`ifdef SEG7_FORCE_EN
        .force_en  (force_en),
        .force_idx (force_idx),
`endif
        .bus       (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic lock, input logic [31:0] d0);
        bus.src_req  = req;
        bus.lock     = lock;
        bus.src_data = {D3, D2, D1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_rep(input int n, input logic [3:0] req, input logic lock, input logic [31:0] d0,
                           input logic [3:0] grant, input logic cs, input logic [31:0] data,
                           input logic [2:0] idx);
        vec_t v;
        v.req = req; v.lock = lock; v.d0 = d0;
        v.grant = grant; v.cs = cs; v.data = data; v.idx = idx;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check_out(input string tag, input logic [3:0] grant, input logic cs,
                             input logic [31:0] data, input logic [2:0] idx);
        check({tag, " grant"}, 32'(bus.src_grant), 32'(grant));
        check({tag, " cs"},    32'(bus.disp_cs),   32'(cs));
        check({tag, " data"},  bus.disp_data,      data);
        check({tag, " idx"},   32'(bus.cur_idx),   32'(idx));
    endtask

    initial begin
        // Round robin over 1011 from reset (cur_idx=3): 0, 1, 3, 0 for 8 clocks each.
        add_rep(8,  4'b1011, 1'b0, D0, 4'b0001, 1'b1, D0, 3'd0);
        add_rep(8,  4'b1011, 1'b0, D0, 4'b0010, 1'b1, D1, 3'd1);
        add_rep(8,  4'b1011, 1'b0, D0, 4'b1000, 1'b1, D3, 3'd3);
        add_rep(8,  4'b1011, 1'b0, D0, 4'b0001, 1'b1, D0, 3'd0);
        add_rep(2,  4'b0000, 1'b0, D0, 4'b0000, 1'b0, D0, 3'd0);
        // Single requester stays on screen across dwell wrap.
        add_rep(11, 4'b0001, 1'b0, D0, 4'b0001, 1'b1, D0, 3'd0);
        // Live data tracking.
        add_rep(1,  4'b0001, 1'b0, 32'h1, 4'b0001, 1'b1, 32'h1, 3'd0);
        add_rep(2,  4'b0001, 1'b0, DC, 4'b0001, 1'b1, DC, 3'd0);
        // Hand over to source 2 by drop, then drop to idle with data held.
        add_rep(1,  4'b0100, 1'b0, DC, 4'b0100, 1'b1, D2, 3'd2);
        add_rep(2,  4'b0000, 1'b0, DC, 4'b0000, 1'b0, D2, 3'd2);

        drive(4'b0000, 1'b0, D0);
        #12;
        check_out("reset", 4'b0000, 1'b0, 32'h0, 3'd3);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].lock, vecs[i].d0);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].cs, vecs[i].data, vecs[i].idx);
        end

        // Lock holds source 1 well past expiry; dropping it moves to source 0 at once.
        drive(4'b0010, 1'b0, D0);
        tick();
        check_out("lock_start", 4'b0010, 1'b1, D1, 3'd1);
        drive(4'b0011, 1'b1, D0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("lock_hold%0d grant", c), 32'(bus.src_grant), 32'h2);
        end
        drive(4'b0001, 1'b1, D0);
        tick();
        check_out("lock_drop", 4'b0001, 1'b1, D0, 3'd0);

        // Asynchronous reset mid-cycle while showing.
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 4'b0000, 1'b0, 32'h0, 3'd3);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_out("post_reset", 4'b0001, 1'b1, D0, 3'd0);

`ifdef SEG7_FORCE_EN
        force_en  = 1'b1;
        force_idx = 3'd3;
        tick();
        check_out("force", 4'b0000, 1'b1, D3, 3'd3);
        force_en = 1'b0;
        drive(4'b0000, 1'b0, D0);
        tick();
        check_out("force_release", 4'b0000, 1'b0, D3, 3'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
